// File: rtl/mips_debug_pkg.sv
// Shared definitions for the MIPS host debug unit: command codes,
// reply codes and the control FSM state encoding.
package mips_debug_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h4C;   // 'L'
    localparam logic [7:0] CMD_STEP = 8'h53;   // 'S'
    localparam logic [7:0] CMD_RUN  = 8'h52;   // 'R'
    localparam logic [7:0] CMD_DUMP = 8'h44;   // 'D'
    localparam logic [7:0] CMD_HALT = 8'h48;   // 'H', only honoured while running

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] ERR = 8'h3F;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD_LEN  = 4'd1,
        LOAD_DATA = 4'd2,
        STEP      = 4'd3,
        STEP_WAIT = 4'd4,
        RUN       = 4'd5,
        DUMP      = 4'd6,
        SEND_WORD = 4'd7,
        SEND_BYTE = 4'd8
    } dbg_state_t;

endpackage

// File: rtl/mips_debug_unit_word_tx.sv
// Serialises one 32-bit word MSB-first (or a single byte taken from the
// low 8 bits) onto a valid/ready byte handshake, then pulses done.
module debug_word_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        single_byte,
    input  logic [31:0] word,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        done
);

    logic [31:0] shift_r;
    logic [2:0]  left_r;
    logic        tx_valid_r;
    logic        done_r;

    // Load the word on start, advance one byte per accepted handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r    <= 32'h0000_0000;
            left_r     <= 3'd0;
            tx_valid_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start && !tx_valid_r) begin
                shift_r    <= single_byte ? {word[7:0], 24'h00_0000} : word;
                left_r     <= single_byte ? 3'd1 : 3'd4;
                tx_valid_r <= 1'b1;
            end else if (tx_valid_r && tx_ready) begin
                if (left_r == 3'd1) begin
                    tx_valid_r <= 1'b0;
                    done_r     <= 1'b1;
                    left_r     <= 3'd0;
                end else begin
                    shift_r <= {shift_r[23:0], 8'h00};
                    left_r  <= left_r - 3'd1;
                end
            end
        end
    end

    // The top byte of the shift register is the byte on the wire; it only
    // moves on acceptance, so it is stable while the transmitter stalls.
    assign tx_data  = shift_r[31:24];
    assign tx_valid = tx_valid_r;
    assign done     = done_r;

endmodule

// File: rtl/mips_debug_unit.sv
// Host-side debug controller for the pipelined MIPS core: loads
// instruction memory from the UART byte stream, gates the core's advance
// enable for step/run, and streams PC / register contents back.
module mips_debug_unit
    import mips_debug_pkg::*;
#(
    parameter int IMEM_ADDR_W = 8,
    parameter int NREGS       = 32,
    parameter int DATA_W      = 32
) (
    input  logic                   ClockIn,
    input  logic                   Reset,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0]      imem_wdata,
    output logic                   cpu_en,
    input  logic                   cpu_halt,
    input  logic [DATA_W-1:0]      cpu_pc,
    output logic [4:0]             dbg_reg_addr,
    input  logic [DATA_W-1:0]      dbg_reg_data,
    output logic                   busy
);

    localparam logic [4:0] LAST_REG = 5'(NREGS - 1);

    dbg_state_t             state_r;
    logic [7:0]             len_r;
    logic [7:0]             word_cnt_r;
    logic [1:0]             byte_cnt_r;
    logic [23:0]            asm_r;
    logic                   load_last_r;
    logic                   dumping_r;
    logic                   imem_we_r;
    logic [IMEM_ADDR_W-1:0] imem_addr_r;
    logic [DATA_W-1:0]      imem_wdata_r;
    logic                   cpu_en_r;
    logic [4:0]             dbg_reg_addr_r;
    logic                   busy_r;
    logic                   tx_start_r;
    logic                   tx_single_r;
    logic [31:0]            tx_word_r;
    logic                   tx_done_s;

    // Control FSM: command decode, load assembly, step/run gating, dump walk.
    always_ff @(posedge ClockIn or negedge Reset) begin
        if (!Reset) begin
            state_r        <= IDLE;
            len_r          <= 8'd0;
            word_cnt_r     <= 8'd0;
            byte_cnt_r     <= 2'd0;
            asm_r          <= 24'h00_0000;
            load_last_r    <= 1'b0;
            dumping_r      <= 1'b0;
            imem_we_r      <= 1'b0;
            imem_addr_r    <= '0;
            imem_wdata_r   <= '0;
            cpu_en_r       <= 1'b0;
            dbg_reg_addr_r <= 5'd0;
            busy_r         <= 1'b0;
            tx_start_r     <= 1'b0;
            tx_single_r    <= 1'b0;
            tx_word_r      <= 32'h0000_0000;
        end else begin
            tx_start_r <= 1'b0;
            imem_we_r  <= 1'b0;
            // Address moves on only after the write cycle; the last word of a
            // load returns it to 0 for the next load.
            if (imem_we_r) begin
                imem_addr_r <= load_last_r ? '0 : imem_addr_r + IMEM_ADDR_W'(1);
            end
            case (state_r)
                IDLE: begin
                    if (rx_valid) begin
                        busy_r <= 1'b1;
                        case (rx_data)
                            CMD_LOAD: state_r <= LOAD_LEN;
                            CMD_STEP: begin
                                state_r  <= STEP;
                                cpu_en_r <= 1'b1;
                            end
                            CMD_RUN: begin
                                state_r  <= RUN;
                                cpu_en_r <= 1'b1;
                            end
                            CMD_DUMP: begin
                                state_r        <= DUMP;
                                dumping_r      <= 1'b1;
                                dbg_reg_addr_r <= 5'd0;
                            end
                            default: begin
                                tx_word_r   <= {24'h00_0000, ERR};
                                tx_single_r <= 1'b1;
                                tx_start_r  <= 1'b1;
                                state_r     <= SEND_BYTE;
                            end
                        endcase
                    end
                end
                LOAD_LEN: begin
                    if (rx_valid) begin
                        len_r      <= rx_data;
                        word_cnt_r <= 8'd0;
                        byte_cnt_r <= 2'd0;
                        if (rx_data == 8'd0) begin
                            tx_word_r   <= {24'h00_0000, ACK};
                            tx_single_r <= 1'b1;
                            tx_start_r  <= 1'b1;
                            state_r     <= SEND_BYTE;
                        end else begin
                            state_r <= LOAD_DATA;
                        end
                    end
                end
                LOAD_DATA: begin
                    if (rx_valid) begin
                        asm_r      <= {asm_r[15:0], rx_data};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            imem_we_r    <= 1'b1;
                            imem_wdata_r <= {asm_r, rx_data};
                            word_cnt_r   <= word_cnt_r + 8'd1;
                            if (word_cnt_r == len_r - 8'd1) begin
                                load_last_r <= 1'b1;
                                tx_word_r   <= {24'h00_0000, ACK};
                                tx_single_r <= 1'b1;
                                tx_start_r  <= 1'b1;
                                state_r     <= SEND_BYTE;
                            end else begin
                                load_last_r <= 1'b0;
                            end
                        end
                    end
                end
                STEP: begin
                    cpu_en_r <= 1'b0;
                    state_r  <= STEP_WAIT;
                end
                STEP_WAIT: begin
                    // Pipeline has settled for one cycle; capture the PC.
                    tx_word_r   <= cpu_pc;
                    tx_single_r <= 1'b0;
                    tx_start_r  <= 1'b1;
                    state_r     <= SEND_WORD;
                end
                RUN: begin
                    if (cpu_halt || (rx_valid && (rx_data == CMD_HALT))) begin
                        cpu_en_r <= 1'b0;
                        state_r  <= STEP_WAIT;
                    end
                end
                DUMP: begin
                    // Register file reads asynchronously on dbg_reg_addr.
                    tx_word_r   <= dbg_reg_data;
                    tx_single_r <= 1'b0;
                    tx_start_r  <= 1'b1;
                    state_r     <= SEND_WORD;
                end
                SEND_WORD: begin
                    if (tx_done_s) begin
                        if (dumping_r && (dbg_reg_addr_r != LAST_REG)) begin
                            dbg_reg_addr_r <= dbg_reg_addr_r + 5'd1;
                            state_r        <= DUMP;
                        end else begin
                            dumping_r      <= 1'b0;
                            dbg_reg_addr_r <= 5'd0;
                            busy_r         <= 1'b0;
                            state_r        <= IDLE;
                        end
                    end
                end
                SEND_BYTE: begin
                    if (tx_done_s) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                default: begin
                    cpu_en_r  <= 1'b0;
                    dumping_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    debug_word_tx u_word_tx (
        .clk         (ClockIn),
        .rst_n       (Reset),
        .start       (tx_start_r),
        .single_byte (tx_single_r),
        .word        (tx_word_r),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .done        (tx_done_s)
    );

    assign imem_we      = imem_we_r;
    assign imem_addr    = imem_addr_r;
    assign imem_wdata   = imem_wdata_r;
    assign cpu_en       = cpu_en_r;
    assign dbg_reg_addr = dbg_reg_addr_r;
    assign busy         = busy_r;

endmodule
